// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one 1024x32 single-port memory between
// instruction fetch (read-only) and data memory (read/write) requesters.
//
// Ports:
//   clock, reset_n                  clock and async active-low reset
//   if_req/if_addr                  fetch request and byte address
//   if_gnt/if_rvalid/if_rdata       fetch grant, data-valid, data
//   dm_req/dm_we/dm_addr/dm_wdata   data request, write flag, address, store data
//   dm_gnt/dm_rvalid/dm_rdata       data grant, completion, load data
//   mem_en/mem_we/mem_addr          memory command, write enable, word index
//   mem_wdata/mem_rdata             memory write data, read data (MEM_LAT later)
//   busy                            high whenever the sequencer is not idle
module unified_mem_arbiter #(
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;

    logic [3:0]  r_lat_cnt;
    logic [3:0]  r_starve_cnt;
    logic        r_win_if;
    logic        r_we;

    logic        r_if_gnt;
    logic        r_if_rvalid;
    logic [31:0] r_if_rdata;
    logic        r_dm_gnt;
    logic        r_dm_rvalid;
    logic [31:0] r_dm_rdata;
    logic        r_mem_en;
    logic        r_mem_we;
    logic [9:0]  r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_busy;

    logic        w_take;
    logic        w_pick_if;
    logic        w_last;
    logic        w_unused_bits;

    // Only the word index within a 4 KB window reaches the memory.
    assign w_unused_bits = ^{if_addr[31:12], if_addr[1:0],
                             dm_addr[31:12], dm_addr[1:0]};

    // Arbitration happens in IDLE and RESP; data wins a collision
    // unless fetch has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        w_take    = 1'b0;
        w_pick_if = 1'b0;
        w_last    = 1'b0;
        if ((r_state == S_IDLE) || (r_state == S_RESP)) begin
            w_take = if_req | dm_req;
        end
        w_pick_if = if_req & (~dm_req | (r_starve_cnt == STARVE_LIM));
        w_last    = (r_state == S_WAIT) && (r_lat_cnt == LAT_M1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:  w_state_nx = w_take ? S_ISSUE : S_IDLE;
            S_ISSUE: w_state_nx = S_WAIT;
            S_WAIT:  w_state_nx = w_last ? S_RESP : S_WAIT;
            S_RESP:  w_state_nx = w_take ? S_ISSUE : S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lat_cnt    <= 4'd0;
            r_starve_cnt <= 4'd0;
            r_win_if     <= 1'b0;
            r_we         <= 1'b0;
        end else begin
            if ((r_state == S_WAIT) && !w_last) begin
                r_lat_cnt <= r_lat_cnt + 4'd1;
            end else begin
                r_lat_cnt <= 4'd0;
            end
            if (w_take) begin
                r_win_if <= w_pick_if;
                r_we     <= ~w_pick_if & dm_we;
                if (w_pick_if) begin
                    r_starve_cnt <= 4'd0;
                end else if (if_req && (r_starve_cnt != STARVE_LIM)) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end
        end
    end

    // Every output is a flop loaded from the next-cycle decision.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_if_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_dm_gnt    <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_dm_rdata  <= 32'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 10'd0;
            r_mem_wdata <= 32'd0;
            r_busy      <= 1'b0;
        end else begin
            r_if_gnt    <= w_take & w_pick_if;
            r_dm_gnt    <= w_take & ~w_pick_if;
            r_mem_en    <= w_take;
            r_mem_we    <= w_take & ~w_pick_if & dm_we;
            r_mem_addr  <= 10'd0;
            r_mem_wdata <= 32'd0;
            if (w_take) begin
                r_mem_addr  <= w_pick_if ? if_addr[11:2] : dm_addr[11:2];
                r_mem_wdata <= w_pick_if ? 32'd0 : dm_wdata;
            end
            r_if_rvalid <= w_last & r_win_if;
            r_dm_rvalid <= w_last & ~r_win_if;
            if (w_last && r_win_if) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_last && !r_win_if && !r_we) begin
                r_dm_rdata <= mem_rdata;
            end
            r_busy <= (w_state_nx != S_IDLE);
        end
    end

    assign if_gnt    = r_if_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign dm_gnt    = r_dm_gnt;
    assign dm_rvalid = r_dm_rvalid;
    assign dm_rdata  = r_dm_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported 1024x32 word memory between two pipeline requesters: the instruction-fetch stage (read-only) and the data-memory stage (read/write).
- Arbitrates with fixed data priority plus a fetch anti-starvation guard.
- Sequences each access through a fixed-latency memory.
- Returns read data or write completion to the winning requester.

Parameters:
MEM_LAT, 2, memory read latency in cycles from mem_en to valid mem_rdata; legal 1..15
STARVE_LIMIT, 3, consecutive data grants allowed while fetch waits before fetch is forced; legal 1..15

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
if_req  input  1  fetch request; held until if_gnt seen
if_addr  input  32  fetch byte address
if_gnt  output  1  one-cycle grant pulse to fetch
if_rvalid  output  1  one-cycle fetch data-valid pulse
if_rdata  output  32  fetched word
dm_req  input  1  data request; held until dm_gnt seen
dm_we  input  1  1 = write, 0 = read
dm_addr  input  32  data byte address
dm_wdata  input  32  store data
dm_gnt  output  1  one-cycle grant pulse to data
dm_rvalid  output  1  one-cycle completion pulse (read data or write ack)
dm_rdata  output  32  loaded word
mem_en  output  1  memory command strobe
mem_we  output  1  memory write enable
mem_addr  output  10  memory word index
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid MEM_LAT cycles after mem_en
busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clock, reset_n).
- Reset:
  - All outputs go to 0 immediately and asynchronously, including mem_we.
  - State goes to IDLE; latency and starvation counters clear.
  - An in-flight access is abandoned: no rvalid is produced for it.
- Timing convention: the request is sampled at the edge ending cycle 0.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE and RESP both arbitrate.
  - If any request is pending at the edge, go to ISSUE and latch the winner, we, addr and wdata.
  - Otherwise go to (or stay in) IDLE.
- ISSUE lasts 1 cycle (cycle 1):
  - The winner's gnt is high.
  - mem_en=1; mem_we=dm_we for a data write, else 0.
  - mem_addr = latched addr[11:2]. addr[1:0] and addr[31:12] are ignored, so addresses wrap every 4 KB.
  - mem_wdata = latched wdata.
  - Next state is WAIT.
- WAIT lasts exactly MEM_LAT cycles (cycles 2..MEM_LAT+1), with mem_en=mem_we=0.
  - At the edge ending the last WAIT cycle, mem_rdata is captured into the winner's rdata register, for reads only.
  - Next state is RESP.
- RESP lasts 1 cycle (cycle MEM_LAT+2):
  - The winner's rvalid is high.
  - For a write, dm_rvalid pulses and dm_rdata keeps its previous value.
  - The non-winner's rdata is never modified.
- Throughput: at most one access every MEM_LAT+2 cycles. Back-to-back issue occurs when a request is present in RESP.
- Requester rules:
  - Hold req, addr, we and wdata stable until gnt is seen; req may drop the cycle after gnt.
  - req is ignored in ISSUE and WAIT.
  - Both requesters may have at most one access outstanding.
- Arbitration (when both requests are high):
  - dm wins unless starve_cnt == STARVE_LIMIT, in which case if wins.
  - Only one requester high: that requester wins.
- starve_cnt (4-bit, saturating at STARVE_LIMIT):
  - Increments on each dm grant made while if_req is high.
  - Clears on any if grant.
  - Otherwise holds.
- gnt and rvalid are never high for both requesters in the same cycle.
- busy = (state != IDLE).

Test Plan:
- Reset values: assert reset_n=0 mid-simulation. All outputs must be 0 within the same cycle with no clock edge; after release, busy=0.
- Single fetch read (MEM_LAT=2): if_req with if_addr=0x0000_0014 in cycle 0.
  - if_gnt=1, mem_en=1, mem_addr=5 in cycle 1.
  - Memory drives 0x8C22_0004 in cycle 3.
  - if_rvalid=1, if_rdata=0x8C22_0004 in cycle 4.
- Collision: if_req and dm_req (read, dm_addr=0x40) both high in cycle 0 with starve_cnt=0.
  - dm_gnt in cycle 1 with mem_addr=16.
  - if_gnt in cycle 5, issued from RESP with no IDLE cycle.
- Starvation guard (STARVE_LIMIT=2): both requests re-asserted immediately after each gnt for 6 grants. Grant order must be D,D,I,D,D,I.
- Write: dm_req=1, dm_we=1, dm_addr=0x10, dm_wdata=0xDEAD_BEEF.
  - Cycle 1: mem_en=1, mem_we=1, mem_addr=4, mem_wdata=0xDEAD_BEEF.
  - mem_we=0 in all other cycles.
  - dm_rvalid pulses in cycle 4; dm_rdata is unchanged.
- Reset mid-access: reset_n low during WAIT of a fetch.
  - No if_rvalid is produced.
  - After release, a dm read to 0x8 completes normally with rvalid 4 cycles after issue request.
